// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared constants, frame FSM states and FIFO entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   localparam int         PS2_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

endpackage

`default_nettype wire

// File: rtl/ps2_fifo.sv
// ============================================================================
// ps2_fifo : scancode FIFO of {release, code} entries, push/pop in one cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  ps2_entry_t i_push_data,
   input  logic       i_pop,
   output logic       o_valid,
   output ps2_entry_t o_head,
   output logic       o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   ps2_entry_t  mem_q [DEPTH];
   ps2_entry_t  mem_d [DEPTH];
   logic        empty, full, do_pop, do_push;

   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop  = i_pop && !empty;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      do_push = i_push && (!full || do_pop);
      o_drop  = i_push && !do_push;

      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q[AW-1:0]] = i_push_data;

      o_valid = !empty;
      o_head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// ps2_keyboard_rx : PS/2 keyboard frame receiver with break tracking and FIFO
// Option macro PS2_PARITY_CHECK_EN enforces odd parity. Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT_W  = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [7:0] o_code,
   output logic       o_release,
   output logic       o_overflow,
   output logic       o_frame_err
);

   localparam logic [TIMEOUT_W-1:0] WDOG_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   logic [1:0]           clk_sync_q, clk_sync_d;
   logic [1:0]           dat_sync_q, dat_sync_d;
   logic                 clk_prev_q, clk_prev_d;
   ps2_state_e           state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic                 brk_q, brk_d;
   logic                 push_q, push_d;
   ps2_entry_t           push_data_q, push_data_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overflow_q, overflow_d;
`ifdef PS2_PARITY_CHECK_EN
   logic                 parity_q, parity_d;
`endif

   logic       fall, ps2_bit, frame_ok, fifo_drop;
   ps2_entry_t head;

   always_comb begin
      clk_sync_d = {clk_sync_q[0], i_ps2_clk};
      dat_sync_d = {dat_sync_q[0], i_ps2_data};
      clk_prev_d = clk_sync_q[1];
      fall       = clk_prev_q && !clk_sync_q[1];
      ps2_bit    = dat_sync_q[1];
`ifdef PS2_PARITY_CHECK_EN
      frame_ok   = ps2_bit && (^{shift_q, parity_q});
      parity_d   = parity_q;
`else
      frame_ok   = ps2_bit;
`endif

      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      brk_d       = brk_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      frame_err_d = 1'b0;
      overflow_d  = overflow_q || fifo_drop;
      wdog_d      = (state_q == ST_IDLE || fall) ? '0 : wdog_q + WDOG_ONE;

      if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!ps2_bit) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d = {ps2_bit, shift_q[7:1]};
               if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
               else                                    bit_cnt_d = bit_cnt_q + 3'd1;
            end
            ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               parity_d = ps2_bit;
`endif
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!frame_ok) begin
                  frame_err_d = 1'b1;
               end else if (shift_q == PS2_BREAK_CODE) begin
                  brk_d = 1'b1;
               end else begin
                  push_d      = 1'b1;
                  push_data_d = '{brk: brk_q, code: shift_q};
                  brk_d       = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE && wdog_q == '1) begin
         // stalled line: abandon the frame and any pending break prefix
         state_d     = ST_IDLE;
         brk_d       = 1'b0;
         frame_err_d = 1'b1;
         wdog_d      = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clk_sync_q  <= 2'b11;
         dat_sync_q  <= 2'b11;
         clk_prev_q  <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         wdog_q      <= '0;
         brk_q       <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         clk_sync_q  <= clk_sync_d;
         dat_sync_q  <= dat_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         wdog_q      <= wdog_d;
         brk_q       <= brk_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
`ifdef PS2_PARITY_CHECK_EN
         parity_q    <= parity_d;
`endif
      end
   end

   ps2_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (push_q),
      .i_push_data (push_data_q),
      .i_pop       (i_ready),
      .o_valid     (o_valid),
      .o_head      (head),
      .o_drop      (fifo_drop)
   );

   assign o_code      = head.code;
   assign o_release   = head.brk;
   assign o_overflow  = overflow_q;
   assign o_frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
// ============================================================================
// tb_ps2_keyboard_rx : self-checking bench for ps2_keyboard_rx
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT_W  = 8;
   localparam int HALF       = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ready = 1'b0;
   logic       o_valid, o_release, o_overflow, o_frame_err;
   logic [7:0] o_code;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] got[$];
   logic [8:0] exp_q[$];
   int         valid_cycles = 0;
   int         err_cycles = 0;
   int         exp_err = 0;
   bit         model_brk = 1'b0;
   bit         exp_ovf = 1'b0;
   bit         rand_done = 1'b0;

   ps2_keyboard_rx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT_W  (TIMEOUT_W)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ps2_clk   (ps2_clk),
      .i_ps2_data  (ps2_data),
      .i_ready     (ready),
      .o_valid     (o_valid),
      .o_code      (o_code),
      .o_release   (o_release),
      .o_overflow  (o_overflow),
      .o_frame_err (o_frame_err)
   );

   always #5 clk = ~clk;

   // consumer-side observer: records every accepted entry
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid) valid_cycles++;
         if (o_valid && ready) got.push_back({o_release, o_code});
         if (o_frame_err) err_cycles++;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #2 ready = v;
   endtask

   task automatic ps2_send_bit(input logic b);
      ps2_data = b;
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
   endtask

   function automatic logic odd_par(input logic [7:0] c);
      return ~^c;
   endfunction

   // reference model: frame-level rules of the keyboard protocol
   task automatic model_frame(input logic [7:0] code, input logic par,
                              input logic stop, input bit stalled);
      bit ok;
      ok = stop;
`ifdef PS2_PARITY_CHECK_EN
      ok = ok && (^{code, par});
`endif
      if (!ok) exp_err++;
      else if (code == 8'hF0) model_brk = 1'b1;
      else begin
         if (stalled && (exp_q.size() - got.size()) >= FIFO_DEPTH) exp_ovf = 1'b1;
         else exp_q.push_back({model_brk, code});
         model_brk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] code, input logic par,
                             input logic stop, input bit stalled);
      ps2_send_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_send_bit(code[i]);
      ps2_send_bit(par);
      ps2_send_bit(stop);
      ps2_data = 1'b1;
      wait_clks(2 * HALF);
      model_frame(code, par, stop, stalled);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      ready = 1'b0;
      wait_clks(3);
      got.delete();
      exp_q.delete();
      valid_cycles = 0;
      err_cycles = 0;
      exp_err = 0;
      model_brk = 1'b0;
      exp_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_clks(3);
   endtask

   task automatic test_reset();
      do_reset();
      send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
      checks++;
      if (o_valid !== 1'b1) begin
         errors++; $display("FAIL reset_pre_valid: got %b expected 1", o_valid);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", o_valid);
      end
      checks++;
      if (o_code !== 8'h00) begin
         errors++; $display("FAIL reset_code: got %h expected 00", o_code);
      end
      checks++;
      if (o_release !== 1'b0) begin
         errors++; $display("FAIL reset_release: got %b expected 0", o_release);
      end
      checks++;
      if (o_overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %b expected 0", o_overflow);
      end
      checks++;
      if (o_frame_err !== 1'b0) begin
         errors++; $display("FAIL reset_frame_err: got %b expected 0", o_frame_err);
      end
   endtask

   task automatic test_basic();
      do_reset();
      set_ready(1'b1);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      wait_clks(10);
      checks++;
      if (got.size() != 1) begin
         errors++; $display("FAIL basic_count: got %0d expected 1", got.size());
      end else begin
         checks++;
         if (got[0] !== 9'h01C) begin
            errors++; $display("FAIL basic_entry: got %h expected 01c", got[0]);
         end
      end
      checks++;
      if (valid_cycles != 1) begin
         errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cycles);
      end
      checks++;
      if (err_cycles != 0) begin
         errors++; $display("FAIL basic_frame_err: got %0d expected 0", err_cycles);
      end
   endtask

   task automatic test_break();
      do_reset();
      set_ready(1'b1);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
      wait_clks(10);
      checks++;
      if (got.size() != 1) begin
         errors++; $display("FAIL break_count: got %0d expected 1", got.size());
      end else begin
         checks++;
         if (got[0] !== 9'h11C) begin
            errors++; $display("FAIL break_entry: got %h expected 11c", got[0]);
         end
      end
   endtask

   task automatic test_parity();
      do_reset();
      set_ready(1'b1);
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      wait_clks(10);
`ifdef PS2_PARITY_CHECK_EN
      checks++;
      if (err_cycles != 1) begin
         errors++; $display("FAIL parity_err_pulse: got %0d expected 1", err_cycles);
      end
      checks++;
      if (got.size() != 0) begin
         errors++; $display("FAIL parity_no_entry: got %0d expected 0", got.size());
      end
`else
      checks++;
      if (got.size() != 1 || got[0] !== 9'h01C) begin
         errors++; $display("FAIL parity_ignored: got %0d entries expected one 01c", got.size());
      end
      checks++;
      if (err_cycles != 0) begin
         errors++; $display("FAIL parity_ignored_err: got %0d expected 0", err_cycles);
      end
`endif
      send_frame(8'h2A, odd_par(8'h2A), 1'b0, 1'b0);
      wait_clks(10);
      checks++;
      if (err_cycles != exp_err) begin
         errors++; $display("FAIL stop_err_pulse: got %0d expected %0d", err_cycles, exp_err);
      end
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++; $display("FAIL stop_no_entry: got %0d expected %0d", got.size(), exp_q.size());
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         logic [7:0] c;
         c = 8'(8'h16 + i);
         send_frame(c, odd_par(c), 1'b1, 1'b1);
      end
      checks++;
      if (o_overflow !== exp_ovf) begin
         errors++; $display("FAIL ovf_flag: got %b expected %b", o_overflow, exp_ovf);
      end
      checks++;
      if (o_valid !== 1'b1 || o_code !== 8'h16) begin
         errors++; $display("FAIL ovf_head: got valid %b code %h expected 1 16", o_valid, o_code);
      end
      set_ready(1'b1);
      wait_clks(2 * FIFO_DEPTH + 4);
      checks++;
      if (got.size() != FIFO_DEPTH) begin
         errors++; $display("FAIL ovf_count: got %0d expected %0d", got.size(), FIFO_DEPTH);
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (o_overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b expected 1", o_overflow);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      set_ready(1'b1);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
      ps2_send_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_send_bit(1'(i & 1));
      ps2_data = 1'b1;
      wait_clks((1 << TIMEOUT_W) - HALF - 20);
      checks++;
      if (err_cycles != 0) begin
         errors++; $display("FAIL timeout_early: got %0d expected 0", err_cycles);
      end
      wait_clks(40);
      checks++;
      if (err_cycles != 1) begin
         errors++; $display("FAIL timeout_pulse: got %0d expected 1", err_cycles);
      end
      model_brk = 1'b0;
      send_frame(8'h45, odd_par(8'h45), 1'b1, 1'b0);
      wait_clks(10);
      checks++;
      if (got.size() != 1 || got[0] !== 9'h045) begin
         errors++; $display("FAIL timeout_recover: got %0d entries first %h expected one 045",
                            got.size(), (got.size() > 0) ? got[0] : 9'h000);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_frame(8'h11, odd_par(8'h11), 1'b1, 1'b1);
      send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b1);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b1);
      ps2_send_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_send_bit(1'b1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL midreset_valid: got %b expected 0", o_valid);
      end
      ps2_data = 1'b1;
      wait_clks(5);
      got.delete();
      exp_q.delete();
      model_brk = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_clks(3);
      set_ready(1'b1);
      send_frame(8'h32, odd_par(8'h32), 1'b1, 1'b0);
      wait_clks(10);
      checks++;
      if (got.size() != 1 || got[0] !== 9'h032) begin
         errors++; $display("FAIL midreset_sole: got %0d entries first %h expected one 032",
                            got.size(), (got.size() > 0) ? got[0] : 9'h000);
      end
   endtask

   task automatic test_random();
      do_reset();
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               logic [7:0] c;
               logic       p, s;
               c = ($urandom % 4 == 0) ? 8'hF0 : 8'($urandom);
               p = odd_par(c) ^ ($urandom % 8 == 0);
               s = ($urandom % 10 != 0);
               send_frame(c, p, s, 1'b0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #2 ready = 1'($urandom % 2);
            end
         end
      join
      set_ready(1'b1);
      wait_clks(10);
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count: got %0d expected %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_entry[%0d]: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (err_cycles != exp_err) begin
         errors++; $display("FAIL rand_frame_err: got %0d expected %0d", err_cycles, exp_err);
      end
      checks++;
      if (o_overflow !== 1'b0) begin
         errors++; $display("FAIL rand_overflow: got %b expected 0", o_overflow);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_break();
      test_parity();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL sim_timeout: got no completion expected finish within 5ms");
      $fatal(1, "simulation time limit");
   end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, meaning number of scancode entries buffered (power of two, >=2).
REQ-002 SHALL provide parameter TIMEOUT_W, default 16, meaning width of the inter-edge watchdog counter.
REQ-003 SHALL provide port i_clk  input  1  system clock, all state on its rising edge.
REQ-004 SHALL provide port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port i_ps2_clk  input  1  raw PS/2 clock line, asynchronous to i_clk.
REQ-006 SHALL provide port i_ps2_data  input  1  raw PS/2 data line, asynchronous to i_clk.
REQ-007 SHALL provide port i_ready  input  1  consumer accepts head entry.
REQ-008 SHALL provide port o_valid  output  1  FIFO non-empty, head entry presented.
REQ-009 SHALL provide port o_code  output  8  head scancode (make code; feeds the scancode-to-ASCII lookup).
REQ-010 SHALL provide port o_release  output  1  head entry was preceded by break prefix 0xF0.
REQ-011 SHALL provide port o_overflow  output  1  sticky, a frame was dropped because FIFO full.
REQ-012 SHALL provide port o_frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-013 SHALL synchronise i_ps2_clk and i_ps2_data through two flops each, then detect ps2_clk falling edge with one further register.
REQ-014 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on detected falling edges.
REQ-015 IDLE SHALL move to DATA only when sampled data is 0 (start bit); a 1 SHALL stay in IDLE with no error.
REQ-016 DATA SHALL shift 8 bits LSB first, bit counter 0..7, then go to PARITY.
REQ-017 STOP SHALL accept the frame only if stop bit is 1 and (when enabled, REQ-027) parity over data+parity bit is odd; otherwise pulse o_frame_err and discard.
REQ-018 Accepted code 0xF0 SHALL set an internal break flag and SHALL NOT be pushed.
REQ-019 Any other accepted code SHALL be pushed with o_release = break flag, then break flag cleared.
REQ-020 Push SHALL occur the cycle after the stop-bit edge is detected (E+1); o_valid SHALL be high from E+2 for an empty FIFO.
REQ-021 Pop SHALL occur when o_valid && i_ready; o_code/o_release SHALL update next cycle.
REQ-022 Full FIFO with simultaneous pop and push SHALL accept both; full without pop SHALL drop the push and set o_overflow.
REQ-023 Watchdog SHALL count i_clk cycles while FSM not IDLE, reset on each falling edge; at all-ones SHALL return to IDLE, clear break flag, pulse o_frame_err.
REQ-024 Pop on empty FIFO SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 On i_rst_n low, SHALL asynchronously set FSM IDLE, empty FIFO, break flag 0, watchdog 0, synchronisers 1.
REQ-026 Outputs in reset SHALL be o_valid 0, o_code 0x00, o_release 0, o_overflow 0, o_frame_err 0; a frame in progress SHALL be lost.

Configuration
REQ-027 Macro PS2_PARITY_CHECK_EN defined SHALL enforce odd parity per REQ-017; undefined SHALL ignore the parity bit (stop bit still checked).

Structure
REQ-028 Package ps2_pkg SHALL hold PS2_BREAK_CODE (0xF0), frame FSM state enum, and data bit count 8.
REQ-029 FIFO SHALL be sub-module ps2_fifo (parameterised depth, 9-bit entries {release, code}).

Verification
REQ-030 Frame 0x1C, parity 0, stop 1, i_ready=1 -> one o_valid cycle, o_code 0x1C, o_release 0.
REQ-031 Frames 0xF0 then 0x1C -> single entry o_code 0x1C, o_release 1.
REQ-032 With macro, frame 0x1C parity 1 -> o_frame_err pulse, no entry; without macro -> entry 0x1C.
REQ-033 i_ready=0, FIFO_DEPTH+1 frames 0x16.. -> FIFO_DEPTH entries retained in order, o_overflow 1.
REQ-034 Stop ps2_clk after 4 data bits for 2^TIMEOUT_W cycles -> o_frame_err pulse, next full frame 0x45 received correctly.
REQ-035 Assert i_rst_n low mid-frame with 2 entries queued -> o_valid 0 immediately, next frame 0x32 received as sole entry.
